// File: rtl/jtframe_db15_tx.sv
// DB15 joystick adapter emulation: parallel-load two joystick words, shift out active-low MSB first.
// Latency: JOY_DATA settles on the 4th clk_sys edge after a JOY_CLK/JOY_LOAD pin edge (2-FF sync + edge + output reg).
// Backpressure: none; the reader paces the link and must hold each JOY_CLK phase for at least 4 clk_sys cycles.
module jtframe_db15_tx #(
    parameter int BITS    = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk_sys,
    input  logic            rst_n,
    input  logic [BITS-1:0] joystick1,
    input  logic [BITS-1:0] joystick2,
    input  logic            JOY_CLK,
    input  logic            JOY_LOAD,
    output logic            JOY_DATA,
    output logic            frame_done,
    output logic            overrun,
    output logic            link_idle
);

    localparam int FRAME = 2 * BITS;
    localparam int CW    = $clog2(FRAME + 1);
    localparam int IW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_t;

    logic             clk_s1, clk_s2, clk_h;
    logic             load_s1, load_s2, load_h;
    logic             clk_rise, load_rise, load_fall;
    state_t           state;
    logic [FRAME-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             done_stb;
    logic [IW-1:0]    idle_cnt;

    // Load history resets high so a pin held high out of reset is not seen as an edge.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            clk_h   <= 1'b0;
            load_s1 <= 1'b1;
            load_s2 <= 1'b1;
            load_h  <= 1'b1;
        end else begin
            clk_s1  <= JOY_CLK;
            clk_s2  <= clk_s1;
            clk_h   <= clk_s2;
            load_s1 <= JOY_LOAD;
            load_s2 <= load_s1;
            load_h  <= load_s2;
        end
    end

    assign clk_rise  = clk_s2 & ~clk_h;
    assign load_rise = load_s2 & ~load_h;
    assign load_fall = ~load_s2 & load_h;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sreg       <= '1;
            cnt        <= '0;
            done_stb   <= 1'b0;
            overrun    <= 1'b0;
            JOY_DATA   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            JOY_DATA   <= sreg[FRAME-1];
            frame_done <= done_stb;
            done_stb   <= 1'b0;
            // Load is level-sensitive and overrides any clock edge in the same cycle.
            if (!load_s2) begin
                state   <= LOADED;
                sreg    <= {~joystick1, ~joystick2};
                cnt     <= '0;
                overrun <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (clk_rise) sreg <= {sreg[FRAME-2:0], 1'b1};
                    end
                    LOADED: begin
                        if (load_rise) begin
                            state <= SHIFT;
                            cnt   <= '0;
                        end
                    end
                    SHIFT: begin
                        if (clk_rise) begin
                            sreg <= {sreg[FRAME-2:0], 1'b1};
                            cnt  <= cnt + CW'(1);
                            if (cnt == CW'(FRAME - 1)) begin
                                done_stb <= 1'b1;
                                state    <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (clk_rise) begin
                            sreg    <= {sreg[FRAME-2:0], 1'b1};
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt  <= IW'(TIMEOUT);
            link_idle <= 1'b1;
        end else begin
            if (load_fall)
                idle_cnt <= '0;
            else if (idle_cnt != IW'(TIMEOUT))
                idle_cnt <= idle_cnt + IW'(1);
            link_idle <= (idle_cnt == IW'(TIMEOUT));
        end
    end

endmodule

// File: tb/tb_jtframe_db15_tx.sv
// Bench for jtframe_db15_tx: directed link scenarios plus randomized frames against a bit-list model.
module tb_jtframe_db15_tx;

    localparam int B = 12;
    localparam int F = 2 * B;

    logic         clk_sys = 1'b0;
    logic         rst_n;
    logic [B-1:0] joystick1, joystick2;
    logic         JOY_CLK, JOY_LOAD;
    logic         JOY_DATA, frame_done, overrun, link_idle;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;

    jtframe_db15_tx #(.BITS(B), .TIMEOUT(16)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .overrun    (overrun),
        .link_idle  (link_idle)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (frame_done === 1'b1) fd_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse(input int h, input int l);
        JOY_CLK = 1'b1;
        cyc(h);
        JOY_CLK = 1'b0;
        cyc(l);
    endtask

    task automatic do_load(input int lowc, input int post);
        JOY_LOAD = 1'b0;
        cyc(lowc);
        JOY_LOAD = 1'b1;
        cyc(post);
    endtask

    // Model: the reader sees bit k of {~j1,~j2} (MSB first) after k pulses, then 1s.
    function automatic logic model_bit(input logic [F-1:0] frame, input int k);
        if (k >= F) return 1'b1;
        return frame[F-1-k];
    endfunction

    task automatic shift_frame(input logic [F-1:0] frame, input string tag, input bit rnd);
        int fd0;
        int h, l;
        fd0 = fd_cnt;
        chk({tag, "_bit0"}, JOY_DATA, model_bit(frame, 0));
        for (int k = 1; k <= F; k++) begin
            h = rnd ? $urandom_range(4, 8) : 8;
            l = rnd ? $urandom_range(4, 8) : 8;
            pulse(h, l);
            chk($sformatf("%s_bit%0d", tag, k), JOY_DATA, model_bit(frame, k));
        end
        chk({tag, "_done_cnt"}, fd_cnt - fd0, 1);
    endtask

    initial begin
        logic [F-1:0] frame;
        int fd0;
        rst_n     = 1'b0;
        JOY_CLK   = 1'b0;
        JOY_LOAD  = 1'b1;
        joystick1 = '0;
        joystick2 = '0;
        cyc(2);
        rst_n = 1'b1;

        // Quiet link after reset
        for (int i = 0; i < 100; i++) begin
            chk("reset_state", {JOY_DATA, frame_done, overrun, link_idle}, 4'b1001);
            cyc(1);
        end

        // Directed frame order with exact frame_done timing
        joystick1 = 12'h001;
        joystick2 = 12'h800;
        frame = {~joystick1, ~joystick2};
        do_load(8, 8);
        fd0 = fd_cnt;
        chk("dir_bit0", JOY_DATA, 1'b1);
        for (int k = 1; k < F; k++) begin
            pulse(8, 8);
            chk($sformatf("dir_bit%0d", k), JOY_DATA, model_bit(frame, k));
        end
        chk("dir_bit11_zero", model_bit(frame, 11), 1'b0);
        JOY_CLK = 1'b1;
        cyc(3);
        chk("dir_fd_early", frame_done, 1'b0);
        cyc(1);
        chk("dir_fd_pulse", frame_done, 1'b1);
        cyc(1);
        chk("dir_fd_end", frame_done, 1'b0);
        cyc(3);
        JOY_CLK = 1'b0;
        cyc(8);
        chk("dir_bit24", JOY_DATA, 1'b1);
        chk("dir_fd_cnt", fd_cnt - fd0, 1);
        chk("dir_no_overrun", overrun, 1'b0);

        // Extra clocks after the frame
        pulse(8, 8);
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_data", JOY_DATA, 1'b1);
        pulse(8, 8);
        chk("ovr_hold", overrun, 1'b1);
        chk("ovr_no_fd", fd_cnt - fd0, 1);
        JOY_LOAD = 1'b0;
        cyc(4);
        chk("ovr_clear", overrun, 1'b0);

        // Load priority: clocks during load are ignored, last low cycle sampled
        joystick1 = 12'h000;
        joystick2 = B'($urandom);
        for (int i = 0; i < 4; i++) begin
            JOY_CLK = 1'b1;
            cyc(4);
            JOY_CLK = 1'b0;
            cyc(4);
            chk("ldpri_hold", JOY_DATA, 1'b1);
        end
        joystick1 = 12'hFFF;
        cyc(1);
        JOY_LOAD = 1'b1;
        cyc(6);
        chk("ldpri_first", JOY_DATA, 1'b0);
        shift_frame({~joystick1, ~joystick2}, "ldpri", 1'b0);

        // Randomized frames
        for (int t = 0; t < 8; t++) begin
            joystick1 = B'($urandom);
            joystick2 = B'($urandom);
            do_load($urandom_range(1, 8), $urandom_range(3, 8));
            shift_frame({~joystick1, ~joystick2}, $sformatf("rnd%0d", t), 1'b1);
        end

        // Reset in the middle of a frame
        joystick1 = B'($urandom) | 12'h040;
        joystick2 = B'($urandom);
        do_load(8, 8);
        for (int k = 0; k < 5; k++) pulse(8, 8);
        chk("mid_pre", JOY_DATA, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {JOY_DATA, frame_done, overrun, link_idle}, 4'b1001);
        cyc(3);
        rst_n = 1'b1;
        fd0 = fd_cnt;
        for (int k = 0; k < F; k++) begin
            pulse(8, 8);
            chk("mid_after", JOY_DATA, 1'b1);
        end
        chk("mid_no_fd", fd_cnt - fd0, 0);

        // Idle timeout
        chk("idle_hi", link_idle, 1'b1);
        JOY_LOAD = 1'b0;
        cyc(5);
        chk("idle_drop", link_idle, 1'b0);
        cyc(12);
        chk("idle_still_low", link_idle, 1'b0);
        cyc(4);
        chk("idle_reassert", link_idle, 1'b1);
        JOY_LOAD = 1'b1;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtframe_db15_tx.md
Name: jtframe_db15_tx

Overview:
- Responder (adapter) end of the DB15 serial joystick link: emulates the dual shift-register joystick adapter board driven by JOY_CLK/JOY_LOAD/JOY_DATA.
- Latches two parallel, active-high joystick words while JOY_LOAD is low, then shifts them out active-low, MSB first, on JOY_CLK rising edges.
- Used in loopback benches against the DB15 reader and in FPGA-side adapter bridges; link pins are asynchronous to clk_sys.

Parameters:
- BITS, 12, bits per joystick; frame length = 2*BITS.
- TIMEOUT, 4096, clk_sys cycles without a JOY_LOAD falling edge before link_idle asserts.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- joystick1  in  BITS  player 1 buttons/directions, 1=pressed.
- joystick2  in  BITS  player 2 buttons/directions, 1=pressed.
- JOY_CLK  in  1  serial shift clock from the reader, asynchronous.
- JOY_LOAD  in  1  parallel load, active-low, asynchronous.
- JOY_DATA  out  1  serial data, registered, active-low buttons, idles 1.
- frame_done  out  1  one-cycle pulse when the last frame bit has been clocked out.
- overrun  out  1  sticky; JOY_CLK edges received after the frame ended; cleared by the next load.
- link_idle  out  1  no load seen for TIMEOUT cycles.

Behaviour:
- Reset values: JOY_DATA=1, shift register all 1s, state IDLE, frame_done=0, overrun=0, link_idle=1, idle counter preset to TIMEOUT.
- Sync: JOY_CLK and JOY_LOAD each pass through 2 FFs plus 1 history FF for edge detection. Only synced signals are used internally.
- Latency: JOY_DATA changes on the 4th clk_sys edge after the pin edge. The reader must hold each JOY_CLK phase for at least 4 clk_sys cycles.
- Shift register: 2*BITS wide, loaded with {~joystick1, ~joystick2}. JOY_DATA = register MSB, re-registered every cycle.
- Load: level-sensitive.
  - While synced LOAD=0, the register reloads every cycle and the state goes to LOADED.
  - The frame carries the inputs sampled on the last LOAD-low cycle.
  - CLK edges are ignored while LOAD=0. Load wins over a simultaneous CLK edge.
- States:
  - IDLE: after reset. CLK edges shift 1s in, no flags change.
  - LOADED: LOAD low. Synced LOAD rising edge -> SHIFT with bit count=0.
  - SHIFT: each synced CLK rising edge shifts left, fills the LSB with 1, count++.
    - The edge that makes count==2*BITS pulses frame_done for 1 cycle -> DONE.
    - JOY_DATA is then 1.
  - DONE: each further CLK edge shifts another 1 in and sets overrun. overrun holds until the next synced LOAD=0.
  - Any state: synced LOAD=0 -> LOADED, overrun cleared.
- Count width: $clog2(2*BITS+1). It never wraps; in DONE it holds.
- Idle counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on a synced LOAD falling edge; otherwise increments, saturating at TIMEOUT.
  - link_idle = (counter==TIMEOUT), registered.
- Reset mid-frame: all outputs return to reset values at once (async). The next frame needs a fresh load.
- JOY_CLK falling edges have no effect.

Test Plan:
- Reset, pins held LOAD=1 CLK=0 -> JOY_DATA=1, frame_done=0, overrun=0, link_idle=1. Stays so for 100 cycles with no edges.
- Load/frame order, BITS=12, joystick1=12'h001, joystick2=12'h800: pulse LOAD low 8 cycles, then 24 CLK pulses (8 cycles high, 8 low).
  - JOY_DATA before the first pulse = 1, and 1 after pulses 1–10.
  - JOY_DATA = 0 after pulse 11 (j1[0]) and 0 after pulse 12 (j2[11]).
  - JOY_DATA = 1 after pulses 13–23.
  - frame_done pulses exactly once, 4 cycles after the 24th CLK rise; JOY_DATA=1 afterwards.
- Overrun: continue with 2 extra CLK pulses after the frame -> overrun=1 after the 25th, JOY_DATA=1. Next LOAD low -> overrun=0 within 4 cycles.
- Load priority: CLK toggling while LOAD=0 with joystick1 changing 12'h000->12'hFFF on the last low cycle.
  - No shift occurs.
  - First bit after LOAD rises = 0 (captured 12'hFFF).
- Mid-frame reset: assert rst_n=0 after 5 CLK pulses -> JOY_DATA=1 immediately.
  - After release, further CLK pulses keep JOY_DATA=1 with no frame_done.
- Idle timeout, TIMEOUT=16: no load for 20 cycles -> link_idle=1.
  - A LOAD falling edge drops link_idle within 5 cycles.
  - It reasserts 16 cycles after that load.
